// File: rtl/o_sort_decode.sv
// Decodes sorter output words into labelled spike / merge / end records.
// Keeps a cluster->label table that is compacted after every merge.
module o_sort_decode #(
  parameter int T_WIDTH = 33,
  parameter int C_WIDTH = 10,
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10,
  parameter int C_SLACK = 21,
  parameter int L_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        s_axis_b_tdata,
  input  logic               s_axis_b_tvalid,
  output logic               s_axis_b_tready,
  input  logic               s_axis_b_tlast,
  output logic [1:0]         m_axis_c_kind,
  output logic [T_WIDTH-1:0] m_axis_c_time,
  output logic [X_WIDTH-1:0] m_axis_c_x,
  output logic [Y_WIDTH-1:0] m_axis_c_y,
  output logic [L_WIDTH-1:0] m_axis_c_label,
  output logic [L_WIDTH-1:0] m_axis_c_label_b,
  output logic               m_axis_c_tvalid,
  input  logic               m_axis_c_tready,
  output logic               m_axis_c_tlast,
  output logic [15:0]        err_cnt
);

  localparam int CW1  = C_WIDTH + 1;
  localparam int Y_LO = 1;
  localparam int X_LO = Y_LO + Y_WIDTH;
  localparam int C_LO = X_LO + X_WIDTH;
  localparam int T_LO = C_LO + C_WIDTH;
  localparam int B_LO = 2;
  localparam int A_LO = B_LO + C_WIDTH + C_SLACK;
  localparam logic [CW1-1:0] FULL = {1'b1, {C_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SEND,
    SHIFT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [63:0]        r_word;
  logic               r_last;
  logic [CW1-1:0]     r_count;
  logic [CW1-1:0]     r_idx;
  logic [L_WIDTH-1:0] r_next;
  logic [15:0]        r_err;
  logic [L_WIDTH-1:0] r_tab [2**C_WIDTH];

  logic [1:0]         r_kind;
  logic [T_WIDTH-1:0] r_time;
  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;
  logic [L_WIDTH-1:0] r_lab;
  logic [L_WIDTH-1:0] r_lab_b;
  logic               r_tvalid;
  logic               r_tlast;

  logic [C_WIDTH-1:0] w_clu;
  logic [C_WIDTH-1:0] w_a;
  logic [C_WIDTH-1:0] w_b;
  logic [C_WIDTH-1:0] w_i0;
  logic [C_WIDTH-1:0] w_i1;
  logic               w_spk;
  logic               w_mrg;
  logic               w_hit;
  logic               w_add;
  logic               w_mok;
  logic               w_ok;
  logic               w_move;
  logic               w_done;

  logic [1:0]         w_kind;
  logic [T_WIDTH-1:0] w_time;
  logic [X_WIDTH-1:0] w_x;
  logic [Y_WIDTH-1:0] w_y;
  logic [L_WIDTH-1:0] w_lab;
  logic [L_WIDTH-1:0] w_lab_b;

  assign w_clu = r_word[C_LO +: C_WIDTH];
  assign w_a   = r_word[A_LO +: C_WIDTH];
  assign w_b   = r_word[B_LO +: C_WIDTH];

  // tlast overrides any data encoding, so word classes are exclusive
  assign w_spk = ~r_last & ~r_word[0];
  assign w_mrg = ~r_last & (r_word[1:0] == 2'b11);
  assign w_hit = w_spk & ({1'b0, w_clu} < r_count);
  assign w_add = w_spk & ({1'b0, w_clu} == r_count)
               & (r_count < FULL);
  assign w_mok = w_mrg
               & ({1'b0, w_a} < r_count)
               & ({1'b0, w_b} < r_count)
               & (w_a != w_b);
  assign w_ok  = r_last | w_hit | w_add | w_mok;

  assign w_i0   = r_idx[C_WIDTH-1:0];
  assign w_i1   = w_i0 + C_WIDTH'(1);
  assign w_move = (r_idx + CW1'(1)) < r_count;
  assign w_done = (r_idx + CW1'(2)) >= r_count;

  always_comb begin
    w_kind  = 2'b00;
    w_time  = '0;
    w_x     = '0;
    w_y     = '0;
    w_lab   = '0;
    w_lab_b = '0;
    unique case (1'b1)
      r_last: begin
        w_kind = 2'b11;
      end
      w_hit: begin
        w_kind = 2'b00;
        w_lab  = r_tab[w_clu];
        w_time = r_word[T_LO +: T_WIDTH];
        w_x    = r_word[X_LO +: X_WIDTH];
        w_y    = r_word[Y_LO +: Y_WIDTH];
      end
      w_add: begin
        w_kind = 2'b01;
        w_lab  = r_next;
        w_time = r_word[T_LO +: T_WIDTH];
        w_x    = r_word[X_LO +: X_WIDTH];
        w_y    = r_word[Y_LO +: Y_WIDTH];
      end
      w_mok: begin
        w_kind  = 2'b10;
        w_lab   = r_tab[w_a];
        w_lab_b = r_tab[w_b];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (s_axis_b_tvalid) w_next = DECODE;
      DECODE:
        w_next = w_ok ? SEND : IDLE;
      SEND:
        if (m_axis_c_tready)
          w_next = (r_kind == 2'b10) ? SHIFT : IDLE;
      SHIFT:
        if (w_done) w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Table is not reset; count bounds every valid read
  always_ff @(posedge clk) begin
    if (r_state == DECODE && w_add)
      r_tab[r_count[C_WIDTH-1:0]] <= r_next;
    else if (r_state == SHIFT && w_move)
      r_tab[w_i0] <= r_tab[w_i1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word   <= '0;
      r_last   <= 1'b0;
      r_count  <= '0;
      r_idx    <= '0;
      r_next   <= '0;
      r_err    <= '0;
      r_kind   <= '0;
      r_time   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_lab    <= '0;
      r_lab_b  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (s_axis_b_tvalid) begin
            r_word <= s_axis_b_tdata;
            r_last <= s_axis_b_tlast;
          end
        DECODE:
          if (w_ok) begin
            r_kind   <= w_kind;
            r_time   <= w_time;
            r_x      <= w_x;
            r_y      <= w_y;
            r_lab    <= w_lab;
            r_lab_b  <= w_lab_b;
            r_tlast  <= r_last;
            r_tvalid <= 1'b1;
            if (w_add) begin
              r_count <= r_count + CW1'(1);
              r_next  <= r_next + L_WIDTH'(1);
            end
          end else if (r_err != 16'hFFFF) begin
            r_err <= r_err + 16'd1;
          end
        SEND:
          if (m_axis_c_tready) begin
            r_tvalid <= 1'b0;
            if (r_kind == 2'b11) r_count <= '0;
            if (r_kind == 2'b10) r_idx <= {1'b0, w_b};
          end
        SHIFT:
          if (w_done) r_count <= r_count - CW1'(1);
          else        r_idx   <= r_idx + CW1'(1);
        default: ;
      endcase
    end
  end

  assign s_axis_b_tready  = (r_state == IDLE);
  assign m_axis_c_kind    = r_kind;
  assign m_axis_c_time    = r_time;
  assign m_axis_c_x       = r_x;
  assign m_axis_c_y       = r_y;
  assign m_axis_c_label   = r_lab;
  assign m_axis_c_label_b = r_lab_b;
  assign m_axis_c_tvalid  = r_tvalid;
  assign m_axis_c_tlast   = r_tlast;
  assign err_cnt          = r_err;

endmodule

// File: tb/tb_o_sort_decode.sv
// Scoreboard bench for o_sort_decode: a label-list model predicts
// each record, which is queued on drive and popped on output.
module tb_o_sort_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [1:0]  m_kind;
  logic [32:0] m_time;
  logic [9:0]  m_x;
  logic [9:0]  m_y;
  logic [15:0] m_label;
  logic [15:0] m_label_b;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [15:0] err_cnt;

  o_sort_decode dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_b_tdata   (s_tdata),
    .s_axis_b_tvalid  (s_tvalid),
    .s_axis_b_tready  (s_tready),
    .s_axis_b_tlast   (s_tlast),
    .m_axis_c_kind    (m_kind),
    .m_axis_c_time    (m_time),
    .m_axis_c_x       (m_x),
    .m_axis_c_y       (m_y),
    .m_axis_c_label   (m_label),
    .m_axis_c_label_b (m_label_b),
    .m_axis_c_tvalid  (m_tvalid),
    .m_axis_c_tready  (m_tready),
    .m_axis_c_tlast   (m_tlast),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [32:0] tm;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] lab;
    logic [15:0] lab_b;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  int   mdl_tab[$];
  int   mdl_next = 0;
  int   mdl_err = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   xfers = 0;

  always @(posedge clk)
    if (!rst && m_tvalid && m_tready) xfers <= xfers + 1;

  function automatic rec_t cur();
    return {m_kind, m_time, m_x, m_y, m_label, m_label_b, m_tlast};
  endfunction

  function automatic logic [63:0] spk(input int c, input logic [32:0] t,
                                      input int x, input int y);
    logic [9:0] cc, xx, yy;
    cc = c[9:0];
    xx = x[9:0];
    yy = y[9:0];
    return {t, cc, xx, yy, 1'b0};
  endfunction

  function automatic logic [63:0] mrg(input int a, input int b);
    logic [9:0] aa, bb;
    aa = a[9:0];
    bb = b[9:0];
    return {21'b0, aa, 21'b0, bb, 2'b11};
  endfunction

  // Reference model: list of active labels, compacted on merge
  function automatic bit mdl(input logic [63:0] d, input logic l,
                             output rec_t e);
    int c, a, b;
    e = '0;
    if (l) begin
      mdl_tab.delete();
      e.kind = 2'b11;
      e.last = 1'b1;
      return 1'b1;
    end
    if (d[0] == 1'b0) begin
      c = int'(d[30:21]);
      e.tm = d[63:31];
      e.x  = d[20:11];
      e.y  = d[10:1];
      if (c < mdl_tab.size()) begin
        e.kind = 2'b00;
        e.lab  = 16'(mdl_tab[c]);
        return 1'b1;
      end
      if (c == mdl_tab.size() && c < 1024) begin
        e.kind = 2'b01;
        e.lab  = 16'(mdl_next);
        mdl_tab.push_back(mdl_next);
        mdl_next = (mdl_next + 1) % 65536;
        return 1'b1;
      end
    end else if (d[1] == 1'b1) begin
      a = int'(d[42:33]);
      b = int'(d[11:2]);
      if (a < mdl_tab.size() && b < mdl_tab.size() && a != b) begin
        e.kind  = 2'b10;
        e.lab   = 16'(mdl_tab[a]);
        e.lab_b = 16'(mdl_tab[b]);
        mdl_tab.delete(b);
        return 1'b1;
      end
    end
    e = '0;
    if (mdl_err < 65535) mdl_err++;
    return 1'b0;
  endfunction

  task automatic drive(input logic [63:0] d, input logic l, output bit ok);
    ok = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts cycles from it
  task automatic collect(output rec_t got, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 1;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid) begin
        ok  = 1'b1;
        got = cur();
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (ok && m_tready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [63:0] d, input logic l,
                      output bit has, output rec_t got, output rec_t want,
                      output int lat, output bit seen);
    rec_t e;
    bit   acc;
    has = mdl(d, l, e);
    if (has) exp_q.push_back(e);
    drive(d, l, acc);
    if (!acc) $display("FAIL accept word=%h never taken", d);
    collect(got, lat, seen);
    want = '0;
    if (has && exp_q.size() > 0) want = exp_q.pop_front();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_tab.delete();
    mdl_next = 0;
    mdl_err  = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (cur() !== '0) begin
      n_fail++;
      $display("FAIL reset_fields got=%h want=0", cur());
    end
    n_chk++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tvalid got=%b want=0", m_tvalid);
    end
    n_chk++;
    if (err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err got=%0d want=0", err_cnt);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready got=%b want=1", s_tready);
    end
  endtask

  task automatic test_spikes();
    logic [63:0] w[3];
    bit   has, seen;
    rec_t got, want;
    int   lat;
    w = '{spk(0, 5, 3, 4), spk(1, 6, 3, 4), spk(0, 7, 3, 4)};
    for (int i = 0; i < 3; i++) begin
      xfer(w[i], 1'b0, has, got, want, lat, seen);
      n_chk++;
      if (!has || !seen || got !== want) begin
        n_fail++;
        $display("FAIL spike%0d got=%h want=%h", i, got, want);
      end
      n_chk++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL spike%0d_latency got=%0d want=2", i, lat);
      end
    end
  endtask

  task automatic test_merge();
    logic [63:0] w[9];
    bit   has, seen;
    rec_t got, want;
    int   lat;
    w = '{spk(2, 10, 1, 2), mrg(0, 1), spk(1, 11, 5, 6),
          spk(2, 12, 7, 8), mrg(2, 0), spk(0, 13, 9, 9),
          spk(1, 14, 2, 3), mrg(0, 1), spk(1, 15, 4, 4)};
    for (int i = 0; i < 9; i++) begin
      xfer(w[i], 1'b0, has, got, want, lat, seen);
      n_chk++;
      if (!has || !seen || got !== want) begin
        n_fail++;
        $display("FAIL merge_seq%0d got=%h want=%h", i, got, want);
      end
      n_chk++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL merge_seq%0d_latency got=%0d want=2", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   has, seen, stable;
    rec_t got, want;
    int   lat, x0;
    m_tready = 1'b0;
    xfer(spk(0, 100, 7, 8), 1'b0, has, got, want, lat, seen);
    n_chk++;
    if (!has || !seen || got !== want) begin
      n_fail++;
      $display("FAIL bp_record got=%h want=%h", got, want);
    end
    x0 = xfers;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (m_tvalid !== 1'b1 || cur() !== got || s_tready !== 1'b0)
        stable = 1'b0;
    end
    n_chk++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_hold got=%h tv=%b str=%b want=%h tv=1 str=0",
               cur(), m_tvalid, s_tready, got);
    end
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (xfers - x0 !== 1) begin
      n_fail++;
      $display("FAIL bp_transfers got=%0d want=1", xfers - x0);
    end
    n_chk++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_tvalid_drop got=%b want=0", m_tvalid);
    end
  endtask

  task automatic test_end();
    logic [63:0] w[5];
    logic        l[5];
    bit   has, seen;
    rec_t got, want;
    int   lat;
    do_reset();
    w = '{spk(0, 20, 1, 1), spk(1, 21, 2, 2), spk(2, 22, 3, 3),
          64'hDEAD_BEEF_1234_5671, spk(0, 23, 4, 4)};
    l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      xfer(w[i], l[i], has, got, want, lat, seen);
      n_chk++;
      if (!has || !seen || got !== want) begin
        n_fail++;
        $display("FAIL end_seq%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_errors();
    logic [63:0] w[6];
    bit   has, seen;
    rec_t got, want;
    int   lat;
    do_reset();
    w = '{spk(5, 30, 1, 1), 64'h1, spk(0, 31, 2, 2),
          spk(2, 32, 3, 3), mrg(0, 0), mrg(0, 1)};
    for (int i = 0; i < 6; i++) begin
      xfer(w[i], 1'b0, has, got, want, lat, seen);
      n_chk++;
      if (seen !== has || (has && got !== want)) begin
        n_fail++;
        $display("FAIL err_seq%0d seen=%b got=%h want_out=%b want=%h",
                 i, seen, got, has, want);
      end
      n_chk++;
      if (err_cnt !== 16'(mdl_err)) begin
        n_fail++;
        $display("FAIL err_seq%0d_count got=%0d want=%0d",
                 i, err_cnt, mdl_err);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    bit   has, seen;
    rec_t got, want;
    int   lat;
    m_tready = 1'b0;
    xfer(spk(1, 40, 5, 5), 1'b0, has, got, want, lat, seen);
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midsend_reach got=%b want=1", seen);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (cur() !== '0 || m_tvalid !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midsend_clear got=%h tv=%b err=%0d want=0",
               cur(), m_tvalid, err_cnt);
    end
    rst = 1'b0;
    mdl_tab.delete();
    mdl_next = 0;
    mdl_err  = 0;
    exp_q.delete();
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL midsend_tready got=%b want=1", s_tready);
    end
    xfer(spk(0, 41, 6, 6), 1'b0, has, got, want, lat, seen);
    n_chk++;
    if (!has || !seen || got !== want) begin
      n_fail++;
      $display("FAIL midsend_restart got=%h want=%h", got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_spikes();
    test_merge();
    test_backpressure();
    test_end();
    test_errors();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/o_sort_decode.md
O_SORT_DECODE -- requirements
Module: o_sort_decode

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- T_WIDTH, 33, spike time width
- C_WIDTH, 10, cluster index width
- X_WIDTH, 10, x coordinate width
- Y_WIDTH, 10, y coordinate width
- C_SLACK, 21, merge-word zero padding
- L_WIDTH, 16, global label width
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, sync active-high reset
- s_axis_b_tdata, in, 64, sorter output word
- s_axis_b_tvalid, in, 1, input word valid
- s_axis_b_tready, out, 1, input ready
- s_axis_b_tlast, in, 1, frame end marker
- m_axis_c_kind, out, 2, 00 spike, 01 new-cluster spike, 10 merge, 11 end
- m_axis_c_time, out, T_WIDTH, spike time
- m_axis_c_x, out, X_WIDTH, spike x
- m_axis_c_y, out, Y_WIDTH, spike y
- m_axis_c_label, out, L_WIDTH, spike label, or surviving label on merge
- m_axis_c_label_b, out, L_WIDTH, absorbed label on merge, else 0
- m_axis_c_tvalid, out, 1, output valid
- m_axis_c_tready, in, 1, output ready
- m_axis_c_tlast, out, 1, frame end
- err_cnt, out, 16, saturating count of malformed words

Function
REQ-004 Spike word (bit0=0): y=[10:1], x=[20:11], cluster=[30:21], time=[63:31].
REQ-005 Merge word ([1:0]=11): B=[11:2], A=[42:33]; B is absorbed into A.
REQ-006 Any word with tlast=1 SHALL be an end marker, whatever its data. A tlast=0 word with [1:0]=01 SHALL be malformed.
REQ-007 State: label table of 2**C_WIDTH entries × L_WIDTH bits (combinational read); count (active clusters); next_label.
REQ-008 FSM states IDLE, DECODE, SEND, SHIFT; s_axis_b_tready=1 only in IDLE.
REQ-009 IDLE: on tvalid, capture the word and tlast, then go to DECODE.
REQ-010 DECODE, spike with cluster<count: kind=00, label=table[cluster], then SEND.
REQ-011 DECODE, spike with cluster==count and count<2**C_WIDTH: table[count]=next_label, count+1, next_label+1 (wraps), kind=01, label=old next_label, then SEND.
REQ-012 DECODE, merge with A<count, B<count, A!=B: kind=10, label=table[A], label_b=table[B], then SEND.
REQ-013 DECODE, end marker: kind=11, tlast=1, all data fields 0, then SEND.
REQ-014 DECODE, any other case (cluster>count, table full, bad merge indices, malformed word): err_cnt+1 (saturating at 0xFFFF), no output, return to IDLE.
REQ-015 SEND: m_axis_c_tvalid=1 with all fields held stable until m_axis_c_tready=1.
REQ-016 SEND exit after handshake: merge goes to SHIFT; end marker sets count=0 and goes to IDLE; others go to IDLE. next_label SHALL persist across frames.
REQ-017 SHIFT: idx runs from B to count-2, one entry per cycle, table[idx]=table[idx+1]. After the last move (or immediately if B==count-1), count-1 and return to IDLE.
REQ-018 Latency: m_axis_c_tvalid SHALL rise 2 cycles after the input handshake cycle.
REQ-019 Outputs SHALL be registered. tvalid=0 outside SEND. m_axis_c_label_b=0 unless kind=10.

Reset
REQ-020 rst SHALL clear state to IDLE, count=0, next_label=0, err_cnt=0, and all m_axis_c_* outputs to 0, from any state including mid-SHIFT or mid-SEND. Table contents need not be cleared.
REQ-021 s_axis_b_tready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-022 Reset: hold rst 3 cycles -> all outputs 0, err_cnt=0, s_tready=1 next cycle.
REQ-023 Spikes (cluster,time) (0,5),(1,6),(0,7) with x=3,y=4 -> outputs kind 01 label 0, kind 01 label 1, kind 00 label 0. Each tvalid 2 cycles after accept; times and x/y pass through.
REQ-024 Clusters 0,1,2 created, then merge A=0,B=1 -> kind 10, label 0, label_b 1. Next spike cluster 1 -> kind 00 label 2. A later new spike must use cluster 2.
REQ-025 Hold m_tready=0 for 5 cycles during SEND -> tvalid and fields stable, s_tready=0, exactly one transfer.
REQ-026 Errors: spike cluster 5 with count 0 -> no output, err_cnt=1. Word 0x1 (tlast=0) -> err_cnt=2.
REQ-027 After labels 0..2, send end word (tlast=1) -> kind 11, tlast=1, count=0. Next spike cluster 0 -> kind 01 label 3.
